// File: rtl/fpga_robots_game_tm_arbiter_pkg.sv
// Shared tile-map geometry and lock FSM encodings for the tile map port arbiter.
package fpga_robots_game_tm_arbiter_pkg;

  localparam int TM_AW = 13;
  localparam int TM_DW = 8;

  localparam logic [0:0] LK_IDLE   = 1'b0;
  localparam logic [0:0] LK_LOCKED = 1'b1;

endpackage

// File: rtl/fpga_robots_game_tm_arbiter_rr_pick.sv
// Rotate-by-pointer priority encoder: first set request at or after ptr, searching upward mod NREQ.
module fpga_robots_game_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW:0]   pos;

  // Walk the requests starting at the pointer; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) begin
        pos = pos - (PW+1)'(NREQ);
      end else begin
        pos = pos;
      end
      if (!found && req[pos[PW-1:0]]) begin
        found              = 1'b1;
        gnt[pos[PW-1:0]]   = 1'b1;
        idx                = pos[PW-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fpga_robots_game_tm_arbiter.sv
// Round-robin arbiter sharing the video tile map port, with read-data return routing
// and an optional exclusive lock for read-modify-write sequences.
module fpga_robots_game_tm_arbiter
  import fpga_robots_game_tm_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         rq_val,
  input  logic [TM_AW*NREQ-1:0]   rq_adr,
  input  logic [NREQ-1:0]         rq_wen,
  input  logic [TM_DW*NREQ-1:0]   rq_wrt,
  input  logic [NREQ-1:0]         rq_lck,
  output logic [NREQ-1:0]         rq_gnt,
  output logic [NREQ-1:0]         rd_vld,
  output logic [TM_DW-1:0]        rd_dat,
  output logic                    lk_tmo,
  output logic [TM_AW-1:0]        tm_adr,
  output logic [TM_DW-1:0]        tm_wrt,
  output logic                    tm_wen,
  input  logic [TM_DW-1:0]        tm_red
);

  localparam int         PW     = $clog2(NREQ);
  localparam logic [7:0] LK_LIM = 8'(LOCK_MAX);
  localparam logic [7:0] LK_PRE = 8'(LOCK_MAX - 1);

  logic [PW-1:0]            ptr;
  logic [0:0]               lk_state;
  logic [PW-1:0]            lk_own;
  logic [7:0]               lk_cnt;
  logic [NREQ-1:0]          elig;
  logic [NREQ-1:0]          pick_gnt;
  logic [PW-1:0]            pick_idx;
  logic                     acc;
  logic                     acc_wen;
  logic                     acc_lck;
  logic [TM_AW-1:0]         acc_adr;
  logic [TM_DW-1:0]         acc_wrt;
  logic [RD_LAT:0]          pipe_vld;
  logic [RD_LAT:0][PW-1:0]  pipe_own;

  // While locked only the owner is eligible; once the idle count expires nobody is,
  // so the timeout cycle itself never grants.
  always_comb begin
    elig = rq_val;
    if (lk_state == LK_LOCKED) begin
      if (lk_cnt == LK_LIM) begin
        elig = '0;
      end else begin
        elig = rq_val & (NREQ'(1) << lk_own);
      end
    end else begin
      elig = rq_val;
    end
  end

  fpga_robots_game_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign rq_gnt  = rst ? '0 : pick_gnt;
  assign acc     = |rq_gnt;
  assign acc_wen = |(rq_wen & rq_gnt);
  assign acc_lck = |(rq_lck & rq_gnt);

  // One-hot mux of the granted requester's address and write data.
  always_comb begin
    acc_adr = '0;
    acc_wrt = '0;
    for (int i = 0; i < NREQ; i++) begin
      acc_adr = acc_adr | (rq_adr[i*TM_AW +: TM_AW] & {TM_AW{rq_gnt[i]}});
      acc_wrt = acc_wrt | (rq_wrt[i*TM_DW +: TM_DW] & {TM_DW{rq_gnt[i]}});
    end
  end

  // Pointer, lock FSM with idle counter, and the tile map port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lk_state <= LK_IDLE;
      lk_own   <= '0;
      lk_cnt   <= 8'd0;
      lk_tmo   <= 1'b0;
      tm_adr   <= '0;
      tm_wrt   <= '0;
      tm_wen   <= 1'b0;
    end else begin
      tm_wen <= acc & acc_wen;
      lk_tmo <= 1'b0;
      if (acc) begin
        ptr    <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        tm_adr <= acc_adr;
        tm_wrt <= acc_wrt;
      end
      case (lk_state)
        LK_IDLE: begin
          if (acc && acc_lck) begin
            lk_state <= LK_LOCKED;
            lk_own   <= pick_idx;
            lk_cnt   <= 8'd0;
          end
        end
        LK_LOCKED: begin
          if (acc) begin
            lk_cnt <= 8'd0;
            if (!acc_lck) begin
              lk_state <= LK_IDLE;
            end
          end else if (lk_cnt == LK_LIM) begin
            lk_state <= LK_IDLE;
          end else begin
            lk_cnt <= lk_cnt + 8'd1;
            lk_tmo <= (lk_cnt == LK_PRE);
          end
        end
        default: lk_state <= LK_IDLE;
      endcase
    end
  end

  // Read-owner pipe: stage RD_LAT lines up with tm_red, which is then registered out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_own <= '0;
      rd_vld   <= '0;
      rd_dat   <= '0;
    end else begin
      pipe_vld[0] <= acc & ~acc_wen;
      pipe_own[0] <= pick_idx;
      for (int s = 1; s <= RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_own[s] <= pipe_own[s-1];
      end
      rd_vld <= pipe_vld[RD_LAT] ? (NREQ'(1) << pipe_own[RD_LAT]) : '0;
      if (pipe_vld[RD_LAT]) begin
        rd_dat <= tm_red;
      end
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_tm_arbiter.sv
// Scoreboard bench for the tile map arbiter: directed stimulus pushes expected grants,
// port issues, read responses and lock timeouts; a negedge monitor pops and compares.
module tb_fpga_robots_game_tm_arbiter;

  localparam int NREQ     = 3;
  localparam int RD_LAT   = 1;
  localparam int LOCK_MAX = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     rq_val = '0;
  logic [13*NREQ-1:0]  rq_adr = '0;
  logic [NREQ-1:0]     rq_wen = '0;
  logic [8*NREQ-1:0]   rq_wrt = '0;
  logic [NREQ-1:0]     rq_lck = '0;
  logic [NREQ-1:0]     rq_gnt;
  logic [NREQ-1:0]     rd_vld;
  logic [7:0]          rd_dat;
  logic                lk_tmo;
  logic [12:0]         tm_adr;
  logic [7:0]          tm_wrt;
  logic                tm_wen;
  logic [7:0]          tm_red = 8'h00;

  logic [7:0] mem [8192];
  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {int cyc; int idx; int adr; int dat; int wen;} exp_t;
  exp_t gq[$];
  exp_t iq[$];
  exp_t rq[$];
  exp_t tq[$];

  fpga_robots_game_tm_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk    (clk),
    .rst    (rst),
    .rq_val (rq_val),
    .rq_adr (rq_adr),
    .rq_wen (rq_wen),
    .rq_wrt (rq_wrt),
    .rq_lck (rq_lck),
    .rq_gnt (rq_gnt),
    .rd_vld (rd_vld),
    .rd_dat (rd_dat),
    .lk_tmo (lk_tmo),
    .tm_adr (tm_adr),
    .tm_wrt (tm_wrt),
    .tm_wen (tm_wen),
    .tm_red (tm_red)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tile RAM preload pattern: byte at address a is a[7:0] ^ 0x5A.
  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = init_byte(a);
  end

  // One-cycle-latency tile RAM, write before later reads.
  always @(posedge clk) begin
    if (tm_wen) mem[tm_adr] <= tm_wrt;
    tm_red <= mem[tm_adr];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input int adr, input bit wen, input int wrt, input bit lck);
    rq_val[i]          = v;
    rq_adr[i*13 +: 13] = 13'(adr);
    rq_wen[i]          = wen;
    rq_wrt[i*8 +: 8]   = 8'(wrt);
    rq_lck[i]          = lck;
  endtask

  task automatic exp_xfer(input int c, input int i, input int adr, input int wrt, input int wen);
    gq.push_back('{c, i, 0, 0, 0});
    iq.push_back('{c + 1, i, adr, wrt, wen});
  endtask

  task automatic exp_rd(input int c, input int i, input int dat);
    rq.push_back('{c, i, 0, dat, 0});
  endtask

  // Monitor: compare whenever the DUT presents a grant, an issue slot, a response or a timeout.
  always @(negedge clk) begin
    exp_t e;
    if (rq_gnt != '0) begin
      if (gq.size() == 0) check("gnt_unexpected", 32'(rq_gnt), 32'd0);
      else begin
        e = gq.pop_front();
        check("gnt_cycle", 32'(cyc), 32'(e.cyc));
        check("gnt_vec", 32'(rq_gnt), 32'd1 << e.idx);
      end
    end
    if (iq.size() > 0 && iq[0].cyc == cyc) begin
      e = iq.pop_front();
      check("tm_adr", 32'(tm_adr), 32'(e.adr));
      check("tm_wrt", 32'(tm_wrt), 32'(e.dat));
      check("tm_wen", 32'(tm_wen), 32'(e.wen));
    end
    if (rd_vld != '0) begin
      if (rq.size() == 0) check("rd_unexpected", 32'(rd_vld), 32'd0);
      else begin
        e = rq.pop_front();
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
        check("rd_vld", 32'(rd_vld), 32'd1 << e.idx);
        check("rd_dat", 32'(rd_dat), 32'(e.dat));
      end
    end
    if (lk_tmo) begin
      if (tq.size() == 0) check("tmo_unexpected", 32'(lk_tmo), 32'd0);
      else begin
        e = tq.pop_front();
        check("tmo_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int order [6] = '{0, 1, 2, 0, 1, 2};
    int i;
    int j;
    int t;

    // Reset held with every requester valid: nothing granted, ports idle.
    for (int r = 0; r < NREQ; r++) drive(r, 1'b1, 'h100 + 16*r, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("rst_gnt", 32'(rq_gnt), 32'd0);
      check("rst_tm_wen", 32'(tm_wen), 32'd0);
      check("rst_rd_vld", 32'(rd_vld), 32'd0);
    end

    // Release: round-robin 0,1,2,0,1,2, each requester advancing its address once granted.
    tick();
    rst = 1'b0;
    t = cyc;
    for (int k = 0; k < 6; k++) begin
      i = order[k];
      j = k / 3;
      exp_xfer(t + k, i, 'h100 + 16*i + j, 0, 0);
      exp_rd(t + k + 3, i, init_byte('h100 + 16*i + j));
      tick();
      drive(i, 1'b1, 'h100 + 16*i + j + 1, 1'b0, 0, 1'b0);
    end
    rq_val = '0;
    repeat (4) tick();

    // req1 writes 0x3C to 0x1A5, req2 reads it back right behind.
    t = cyc;
    drive(1, 1'b1, 'h1A5, 1'b1, 'h3C, 1'b0);
    exp_xfer(t, 1, 'h1A5, 'h3C, 1);
    tick();
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(2, 1'b1, 'h1A5, 1'b0, 0, 1'b0);
    exp_xfer(t + 1, 2, 'h1A5, 0, 0);
    exp_rd(t + 4, 2, 'h3C);
    tick();
    drive(2, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (4) tick();

    // req0 locked read then unlocking write; req1 waits until the write is done.
    t = cyc;
    drive(0, 1'b1, 'h020, 1'b0, 0, 1'b1);
    drive(1, 1'b1, 'h030, 1'b0, 0, 1'b0);
    exp_xfer(t, 0, 'h020, 0, 0);
    exp_rd(t + 3, 0, init_byte('h020));
    tick();
    drive(0, 1'b1, 'h020, 1'b1, 'h77, 1'b0);
    exp_xfer(t + 1, 0, 'h020, 'h77, 1);
    tick();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
    exp_xfer(t + 2, 1, 'h030, 0, 0);
    exp_rd(t + 5, 1, init_byte('h030));
    tick();
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (4) tick();

    // req2 takes the lock and goes idle: timeout after four idle cycles, then req0.
    t = cyc;
    drive(2, 1'b1, 'h040, 1'b0, 0, 1'b1);
    drive(0, 1'b1, 'h050, 1'b0, 0, 1'b0);
    exp_xfer(t, 2, 'h040, 0, 0);
    exp_rd(t + 3, 2, init_byte('h040));
    tq.push_back('{t + 5, 0, 0, 0, 0});
    exp_xfer(t + 6, 0, 'h050, 0, 0);
    exp_rd(t + 9, 0, init_byte('h050));
    tick();
    drive(2, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (6) tick();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (4) tick();

    // Two reads in flight, then reset: their responses must never appear.
    t = cyc;
    drive(1, 1'b1, 'h060, 1'b0, 0, 1'b0);
    exp_xfer(t, 1, 'h060, 0, 0);
    tick();
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    drive(2, 1'b1, 'h070, 1'b0, 0, 1'b0);
    exp_xfer(t + 1, 2, 'h070, 0, 0);
    tick();
    drive(2, 1'b0, 0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();

    // Reset while req0 holds the lock: req1 is granted straight after release.
    t = cyc;
    drive(0, 1'b1, 'h080, 1'b0, 0, 1'b1);
    exp_xfer(t, 0, 'h080, 0, 0);
    tick();
    drive(0, 1'b0, 0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1'b1, 'h090, 1'b0, 0, 1'b0);
    exp_xfer(t + 2, 1, 'h090, 0, 0);
    exp_rd(t + 5, 1, init_byte('h090));
    tick();
    drive(1, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (8) tick();

    check("gnt_left", 32'(gq.size()), 32'd0);
    check("issue_left", 32'(iq.size()), 32'd0);
    check("rd_left", 32'(rq.size()), 32'd0);
    check("tmo_left", 32'(tq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
